// File: rtl/sipo_pkg.sv
// Shared defaults and FSM state type for the serial-in / parallel-out deserializer.
package sipo_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned DEPTH_DEF = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/sipo_fifo.sv
// Small synchronous FIFO holding assembled words until downstream accepts them.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sipo_fifo
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  // Advance a pointer, toggling the wrap bit when the index passes DEPTH-1.
  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    if (p[AW-1:0] == AW'(DEPTH - 1)) begin
      return {~p[AW], AW'(0)};
    end
    return p + (AW + 1)'(1);
  endfunction

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop && !o_empty;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update: reset empties the buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  // Storage write; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in / parallel-out deserializer: assembles LSB-first words from
// qualified serial bits and queues them in a small output FIFO.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_i,
  input  logic             valid_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] parallel_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic [7:0]       word_cnt_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_word;
  logic             w_last;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_drop;
  logic             r_overrun;
  logic [7:0]       r_word_cnt;

  assign w_last   = valid_i && (r_bit_cnt == CW'(WIDTH - 1));
  assign w_pop    = valid_o && ready_i;
  assign w_accept = w_last && (!w_full || w_pop);
  assign w_drop   = w_last && w_full && !w_pop;

  // Completed word includes the bit arriving on this edge.
  always_comb begin
    w_word            = r_shift;
    w_word[r_bit_cnt] = serial_i;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: leave IDLE on a valid bit, return after the last bit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (valid_i && !w_last) w_state_nxt = SHIFT;
      SHIFT:   if (w_last)             w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_o = (r_state == SHIFT);
  end

  // Bit counter and shift register, advanced only on qualified bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (valid_i) begin
      r_shift[r_bit_cnt] <= serial_i;
      r_bit_cnt          <= w_last ? '0 : r_bit_cnt + CW'(1);
    end
  end

  // Sticky overrun flag and accepted-word counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_overrun  <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      if (w_drop)   r_overrun  <= 1'b1;
      if (w_accept) r_word_cnt <= r_word_cnt + 8'd1;
    end
  end

  sipo_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_last),
    .i_wdata(w_word),
    .i_pop  (w_pop),
    .o_rdata(parallel_o),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign valid_o    = !w_empty;
  assign overrun_o  = r_overrun;
  assign word_cnt_o = r_word_cnt;

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: directed table, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_sipo_deser;

  localparam int W = 4;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         serial_i;
  logic         valid_i;
  logic         ready_i;
  logic [W-1:0] parallel_o;
  logic         valid_o;
  logic         busy_o;
  logic         overrun_o;
  logic [7:0]   word_cnt_o;

  int total = 0;
  int bad   = 0;
  string phase = "init";

  sipo_deser #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .serial_i  (serial_i),
    .valid_i   (valid_i),
    .ready_i   (ready_i),
    .parallel_o(parallel_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o),
    .overrun_o (overrun_o),
    .word_cnt_o(word_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: bits gathered so far, queue of buffered words, stats.
  int           m_nbits = 0;
  logic [W-1:0] m_part  = '0;
  logic [W-1:0] m_q[$];
  bit           m_ovr   = 1'b0;
  int           m_cnt   = 0;

  task automatic model_edge(input logic s, input logic v, input logic r, input logic rst_n);
    logic [W-1:0] w;
    bit pop;
    bit done;
    if (!rst_n) begin
      m_nbits = 0;
      m_part  = '0;
      m_q.delete();
      m_ovr   = 1'b0;
      m_cnt   = 0;
    end else begin
      pop  = (m_q.size() > 0) && r;
      done = v && (m_nbits == W - 1);
      w = m_part;
      if (v) w[m_nbits] = s;
      if (pop) void'(m_q.pop_front());
      if (done) begin
        if (m_q.size() < D) begin
          m_q.push_back(w);
          m_cnt = (m_cnt + 1) % 256;
        end else begin
          m_ovr = 1'b1;
        end
      end
      if (v) begin
        m_part  = w;
        m_nbits = (m_nbits + 1) % W;
      end
    end
  endtask

  // One comparison of all outputs; parallel_o checked when a word is expected
  // (or forced to zero when pz is set, e.g. straight after reset).
  task automatic expect_out(input string nm, input logic ev, input logic [W-1:0] ep,
                            input logic eb, input logic eo, input logic [7:0] ec,
                            input bit pz);
    bit ok;
    ok = (valid_o === ev) && (busy_o === eb) && (overrun_o === eo) && (word_cnt_o === ec);
    if (ev || pz) ok = ok && (parallel_o === ep);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s/%s t=%0t: got v=%b p=%h b=%b o=%b c=%0d, want v=%b p=%h b=%b o=%b c=%0d",
               phase, nm, $time, valid_o, parallel_o, busy_o, overrun_o, word_cnt_o,
               ev, ep, eb, eo, ec);
    end
  endtask

  task automatic model_check();
    logic [W-1:0] ep;
    ep = (m_q.size() > 0) ? m_q[0] : '0;
    expect_out("model", m_q.size() > 0, ep, m_nbits != 0, m_ovr, 8'(m_cnt), 1'b0);
  endtask

  task automatic tick(input logic s, input logic v, input logic r, input logic rst_n);
    serial_i = s;
    valid_i  = v;
    ready_i  = r;
    reset    = rst_n;
    @(posedge clk);
    model_edge(s, v, r, rst_n);
    #1;
    model_check();
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic r, input logic r_last);
    for (int k = 0; k < W; k++) tick(w[k], 1'b1, (k == W - 1) ? r_last : r, 1'b1);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("reset", 1'b0, '0, 1'b0, 1'b0, 8'd0, 1'b1);
  endtask

  typedef struct {
    logic         s, v, r;
    logic         ev;
    logic [W-1:0] ep;
    logic         eb, eo;
    logic [7:0]   ec;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [W-1:0] wa, wb, wc, wlast;

    serial_i = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    reset    = 1'b0;

    phase = "reset";
    do_reset();

    // Word 1,0,1,1 then a word 0,1 <gap x3> 1,0.
    tbl[0]  = '{1, 1, 1, 0, 4'h0, 1, 0, 8'd0};
    tbl[1]  = '{0, 1, 1, 0, 4'h0, 1, 0, 8'd0};
    tbl[2]  = '{1, 1, 1, 0, 4'h0, 1, 0, 8'd0};
    tbl[3]  = '{1, 1, 1, 1, 4'hD, 0, 0, 8'd1};
    tbl[4]  = '{0, 0, 1, 0, 4'h0, 0, 0, 8'd1};
    tbl[5]  = '{0, 1, 1, 0, 4'h0, 1, 0, 8'd1};
    tbl[6]  = '{1, 1, 1, 0, 4'h0, 1, 0, 8'd1};
    tbl[7]  = '{1, 0, 0, 0, 4'h0, 1, 0, 8'd1};
    tbl[8]  = '{0, 0, 1, 0, 4'h0, 1, 0, 8'd1};
    tbl[9]  = '{1, 0, 0, 0, 4'h0, 1, 0, 8'd1};
    tbl[10] = '{1, 1, 1, 0, 4'h0, 1, 0, 8'd1};
    tbl[11] = '{0, 1, 0, 1, 4'h6, 0, 0, 8'd2};
    tbl[12] = '{0, 0, 0, 1, 4'h6, 0, 0, 8'd2};
    tbl[13] = '{0, 0, 1, 0, 4'h0, 0, 0, 8'd2};
    phase = "table";
    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].s, tbl[i].v, tbl[i].r, 1'b1);
      expect_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ep, tbl[i].eb, tbl[i].eo,
                 tbl[i].ec, 1'b0);
    end

    // Three words with ready low: A and B buffered, C dropped.
    phase = "overrun";
    do_reset();
    wa = 4'h3; wb = 4'hC; wc = 4'h5;
    send_word(wa, 1'b0, 1'b0);
    expect_out("A_buffered", 1'b1, wa, 1'b0, 1'b0, 8'd1, 1'b0);
    for (int k = 0; k < W; k++) begin
      tick(wb[k], 1'b1, 1'b0, 1'b1);
      expect_out("A_held", 1'b1, wa, k != W - 1, 1'b0, 8'(k == W - 1 ? 2 : 1), 1'b0);
    end
    send_word(wc, 1'b0, 1'b0);
    expect_out("C_dropped", 1'b1, wa, 1'b0, 1'b1, 8'd2, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    expect_out("deliver_B", 1'b1, wb, 1'b0, 1'b1, 8'd2, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    expect_out("drained", 1'b0, '0, 1'b0, 1'b1, 8'd2, 1'b0);

    // Full buffer, third word completes on the same edge as a pop.
    phase = "push_pop_full";
    do_reset();
    send_word(wa, 1'b0, 1'b0);
    send_word(wb, 1'b0, 1'b0);
    send_word(wc, 1'b0, 1'b1);
    expect_out("no_drop", 1'b1, wb, 1'b0, 1'b0, 8'd3, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    expect_out("deliver_C", 1'b1, wc, 1'b0, 1'b0, 8'd3, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    expect_out("empty", 1'b0, '0, 1'b0, 1'b0, 8'd3, 1'b0);

    // Reset mid-word with one word buffered.
    phase = "mid_reset";
    do_reset();
    send_word(wa, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    expect_out("before_rst", 1'b1, wa, 1'b1, 1'b0, 8'd1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    expect_out("after_rst", 1'b0, '0, 1'b0, 1'b0, 8'd0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    expect_out("no_pulse", 1'b0, '0, 1'b0, 1'b0, 8'd0, 1'b0);
    send_word(4'hE, 1'b1, 1'b1);
    expect_out("clean_word", 1'b1, 4'hE, 1'b0, 1'b0, 8'd1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    expect_out("one_cycle", 1'b0, '0, 1'b0, 1'b0, 8'd1, 1'b0);

    // 256 back-to-back words: counter wraps, nothing dropped.
    phase = "wrap";
    do_reset();
    wlast = '0;
    for (int n = 0; n < 256; n++) begin
      wlast = W'($urandom);
      send_word(wlast, 1'b1, 1'b1);
    end
    expect_out("wrap0", 1'b1, wlast, 1'b0, 1'b0, 8'd0, 1'b0);

    // Randomized traffic with occasional reset.
    phase = "random";
    for (int n = 0; n < 4000; n++) begin
      tick(1'($urandom), ($urandom_range(3, 0) != 0), 1'($urandom),
           ($urandom_range(149, 0) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
